// File: rtl/mem_scan_reader.sv
// mem_scan_reader: walks an address window of a 1-cycle-latency sync RAM,
// capturing each byte and holding address/data for a dwell period so the
// seven-segment display chain can show a consistent address/data pair.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; outputs hold their reset values
// ISSUE   | mem_addr is stable on the RAM address input
// WAIT    | RAM registers its output; cur_* load from mem_do on exit
// CAPTURE | cur_addr/cur_data just updated, data_valid high this cycle
// DWELL   | hold the displayed byte; count, or wait for step while paused
// DONE    | window finished with WRAP=0; cur_* hold until the next start
module mem_scan_reader #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] START_ADDR   = '0,
  parameter logic [ADDR_W-1:0] END_ADDR     = '1,
  parameter int                DWELL_CYCLES = 50_000_000,
  parameter bit                WRAP         = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_do_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic [DATA_W-1:0] cur_data_o,
  output logic              data_valid_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DWELL   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Counter only has to reach DWELL_CYCLES-1.
  localparam int              CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0] cur_data_q, cur_data_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              advance;

  // Next-state logic: sequencing, dwell timing and address stepping.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    cur_addr_d = cur_addr_q;
    cur_data_d = cur_data_q;
    cnt_d      = cnt_q;
    advance    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          mem_addr_d = START_ADDR;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Load address and data together so data_valid lines up with them.
        cur_data_d = mem_do_i;
        cur_addr_d = mem_addr_q;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: begin
        cnt_d   = '0;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (!pause_i) begin
          if (cnt_q == CNT_LAST) advance = 1'b1;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end else if (step_i) begin
          advance = 1'b1;
        end
        if (advance) begin
          cnt_d = '0;
          // Explicit wrap compare; END_ADDR may be all-ones.
          if (mem_addr_q == END_ADDR) begin
            if (WRAP) begin
              mem_addr_d = START_ADDR;
              state_d    = S_ISSUE;
            end else begin
              state_d    = S_DONE;
            end
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      mem_addr_q <= START_ADDR;
      cur_addr_q <= START_ADDR;
      cur_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      cur_addr_q <= cur_addr_d;
      cur_data_q <= cur_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = 1'b0;
  assign cur_addr_o   = cur_addr_q;
  assign cur_data_o   = cur_data_q;
  assign data_valid_o = (state_q == S_CAPTURE);
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_scan_reader.sv
// Directed bench for mem_scan_reader: one instance with WRAP=0 (a) and one
// with WRAP=1 (b), window FF0F..FF11, dwell of 4 cycles.
module tb_mem_scan_reader;

  logic        clk;
  logic        reset_n;
  logic        start_a, pause_a, step_a;
  logic        start_b, pause_b, step_b;
  logic [15:0] mem_addr_a, mem_addr_b, cur_addr_a, cur_addr_b;
  logic [7:0]  mem_do_a, mem_do_b, cur_data_a, cur_data_b;
  logic        we_a, we_b, dv_a, dv_b, busy_a, busy_b, done_a, done_b;

  int n_chk  = 0;
  int n_fail = 0;

  mem_scan_reader #(.ADDR_W(16), .DATA_W(8), .START_ADDR(16'hFF0F), .END_ADDR(16'hFF11),
                    .DWELL_CYCLES(4), .WRAP(1'b0)) u_a (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_a), .pause_i(pause_a), .step_i(step_a),
    .mem_addr_o(mem_addr_a), .mem_we_o(we_a), .mem_do_i(mem_do_a),
    .cur_addr_o(cur_addr_a), .cur_data_o(cur_data_a), .data_valid_o(dv_a),
    .busy_o(busy_a), .done_o(done_a));

  mem_scan_reader #(.ADDR_W(16), .DATA_W(8), .START_ADDR(16'hFF0F), .END_ADDR(16'hFF11),
                    .DWELL_CYCLES(4), .WRAP(1'b1)) u_b (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_b), .pause_i(pause_b), .step_i(step_b),
    .mem_addr_o(mem_addr_b), .mem_we_o(we_b), .mem_do_i(mem_do_b),
    .cur_addr_o(cur_addr_b), .cur_data_o(cur_data_b), .data_valid_o(dv_b),
    .busy_o(busy_b), .done_o(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [15:0] a);
    case (a)
      16'hFF0F: return 8'hED;
      16'hFF10: return 8'h3C;
      16'hFF11: return 8'hA5;
      default:  return 8'h00;
    endcase
  endfunction

  // Synchronous RAMs with one cycle of read latency.
  always @(posedge clk) begin
    mem_do_a <= ram_rd(mem_addr_a);
    mem_do_b <= ram_rd(mem_addr_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_a(input string tag, input logic [15:0] addr, input logic [7:0] data);
    chk({tag, "_dv"},   32'(dv_a), 32'd1);
    chk({tag, "_addr"}, 32'(cur_addr_a), 32'(addr));
    chk({tag, "_data"}, 32'(cur_data_a), 32'(data));
    chk({tag, "_we"},   32'(we_a), 32'd0);
  endtask

  task automatic chk_b(input string tag, input logic [15:0] addr, input logic [7:0] data);
    chk({tag, "_dv"},   32'(dv_b), 32'd1);
    chk({tag, "_addr"}, 32'(cur_addr_b), 32'(addr));
    chk({tag, "_data"}, 32'(cur_data_b), 32'(data));
    chk({tag, "_done"}, 32'(done_b), 32'd0);
  endtask

  // Advance n cycles on instance b, requiring no data_valid and no address change.
  task automatic quiet_b(input string tag, input int n, input logic [15:0] addr);
    for (int i = 0; i < n; i++) begin
      tick(1);
      chk({tag, "_dv0"}, 32'(dv_b), 32'd0);
      chk({tag, "_hold"}, 32'(cur_addr_b), 32'(addr));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; pause_a = 1'b0; step_a = 1'b0;
    start_b = 1'b0; pause_b = 1'b0; step_b = 1'b0;
    tick(2);
    chk("rst_mem_addr", 32'(mem_addr_a), 32'hFF0F);
    chk("rst_cur_addr", 32'(cur_addr_a), 32'hFF0F);
    chk("rst_cur_data", 32'(cur_data_a), 32'h00);
    chk("rst_dv",       32'(dv_a), 32'd0);
    chk("rst_busy",     32'(busy_a), 32'd0);
    chk("rst_done",     32'(done_a), 32'd0);
    chk("rst_we",       32'(we_a), 32'd0);
    chk("rst_b_addr",   32'(mem_addr_b), 32'hFF0F);
    reset_n = 1'b1;
    tick(2);
    chk("idle_busy", 32'(busy_a), 32'd0);

    // ---- WRAP=0 scan ----
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("a_issue_busy", 32'(busy_a), 32'd1);
    chk("a_issue_dv",   32'(dv_a), 32'd0);
    tick(1);
    chk("a_wait_dv", 32'(dv_a), 32'd0);
    tick(1);
    chk_a("a_b0", 16'hFF0F, 8'hED);
    // start while busy must not disturb the cadence
    tick(2);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(3);
    chk("a_b1_early", 32'(dv_a), 32'd0);
    chk("a_b1_hold",  32'(cur_addr_a), 32'hFF0F);
    tick(1);
    chk_a("a_b1", 16'hFF10, 8'h3C);
    // step without pause is ignored
    tick(2);
    step_a = 1'b1;
    tick(1);
    step_a = 1'b0;
    chk("a_step_ign_addr", 32'(mem_addr_a), 32'hFF10);
    tick(3);
    chk("a_b2_early", 32'(dv_a), 32'd0);
    tick(1);
    chk_a("a_b2", 16'hFF11, 8'hA5);
    tick(4);
    chk("a_pre_done", 32'(done_a), 32'd0);
    tick(1);
    chk("a_done",      32'(done_a), 32'd1);
    chk("a_done_busy", 32'(busy_a), 32'd0);
    tick(3);
    chk("a_done_hold", 32'(done_a), 32'd1);
    chk("a_done_addr", 32'(cur_addr_a), 32'hFF11);
    chk("a_done_data", 32'(cur_data_a), 32'hA5);
    chk("a_done_dv",   32'(dv_a), 32'd0);
    // restart from DONE
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("a_rs_done", 32'(done_a), 32'd0);
    chk("a_rs_busy", 32'(busy_a), 32'd1);
    tick(2);
    chk_a("a_rs_b0", 16'hFF0F, 8'hED);

    // ---- WRAP=1 scan ----
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    tick(2);
    chk_b("b_b0", 16'hFF0F, 8'hED);
    tick(7);
    chk_b("b_b1", 16'hFF10, 8'h3C);
    tick(7);
    chk_b("b_b2", 16'hFF11, 8'hA5);
    tick(7);
    chk_b("b_wrap", 16'hFF0F, 8'hED);
    chk("b_wrap_busy", 32'(busy_b), 32'd1);

    // ---- pause and single step ----
    pause_b = 1'b1;
    quiet_b("b_p0", 7, 16'hFF0F);
    for (int k = 0; k < 3; k++) begin
      logic [15:0] ea;
      logic [7:0]  ed;
      ea = (k == 0) ? 16'hFF10 : (k == 1) ? 16'hFF11 : 16'hFF0F;
      ed = ram_rd(ea);
      step_b = 1'b1;
      tick(1);
      step_b = 1'b0;
      chk("b_step_addr", 32'(mem_addr_b), 32'(ea));
      chk("b_step_dv0",  32'(dv_b), 32'd0);
      tick(2);
      chk_b("b_step", ea, ed);
      quiet_b("b_pq", 7, ea);
    end

    // pause released together with a step: step ignored, counter resumes
    pause_b = 1'b0;
    step_b  = 1'b1;
    tick(1);
    step_b  = 1'b0;
    chk("b_rel_addr", 32'(mem_addr_b), 32'hFF0F);
    tick(2);
    chk("b_rel_dv0", 32'(dv_b), 32'd0);
    tick(3);
    chk_b("b_rel", 16'hFF10, 8'h3C);

    // ---- reset during WAIT ----
    tick(6);
    chk("b_wait_busy", 32'(busy_b), 32'd1);
    chk("b_wait_addr", 32'(mem_addr_b), 32'hFF11);
    chk("b_wait_dv",   32'(dv_b), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("b_arst_maddr", 32'(mem_addr_b), 32'hFF0F);
    chk("b_arst_caddr", 32'(cur_addr_b), 32'hFF0F);
    chk("b_arst_cdata", 32'(cur_data_b), 32'h00);
    chk("b_arst_busy",  32'(busy_b), 32'd0);
    chk("b_arst_dv",    32'(dv_b), 32'd0);
    chk("b_arst_done",  32'(done_b), 32'd0);
    tick(2);
    reset_n = 1'b1;
    quiet_b("b_post_rst", 4, 16'hFF0F);
    chk("b_post_busy", 32'(busy_b), 32'd0);
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    chk("b_rs_addr", 32'(mem_addr_b), 32'hFF0F);
    tick(2);
    chk_b("b_rs_b0", 16'hFF0F, 8'hED);
    chk("b_we", 32'(we_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_scan_reader.md
Name: mem_scan_reader

Overview:
- Read-side companion to the inferred-RAM write path.
- Walks a configurable address window of the synchronous single-port RAM (16-bit address, 8-bit data), one read per step.
- Captures each byte and holds address and data stable for a dwell period, so the hex_to_sseg/disp_mux chain can show them.
- Supports free-run, pause and single-step operation.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- START_ADDR, 16'h0000, first address scanned.
- END_ADDR, 16'hFFFF, last address scanned, inclusive; must be >= START_ADDR.
- DWELL_CYCLES, 50_000_000, clocks each byte is held in RUN mode; must be >= 1.
- WRAP, 1, 1 = restart at START_ADDR after END_ADDR; 0 = stop and assert done.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse; begins a scan from START_ADDR.
- pause, input, 1, level; while 1, the dwell counter freezes and no new read is issued.
- step, input, 1, single-cycle pulse; honoured only while paused, advances exactly one address.
- mem_addr, output, ADDR_W, address driven to the RAM addr input.
- mem_we, output, 1, RAM write enable; constant 0.
- mem_do, input, DATA_W, RAM read data; valid the cycle after mem_addr is presented.
- cur_addr, output, ADDR_W, address of the displayed byte.
- cur_data, output, DATA_W, displayed byte.
- data_valid, output, 1, 1-cycle pulse when cur_addr/cur_data update.
- busy, output, 1, 1 in any state other than IDLE/DONE.
- done, output, 1, level; 1 after the last address when WRAP=0, cleared by start.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - mem_addr=START_ADDR, cur_addr=START_ADDR, cur_data=0.
  - data_valid=0, busy=0, done=0, dwell counter=0.
  - Reset may assert mid-scan; release resumes in IDLE with no partial update.
- mem_we is tied 0 in every state; the block never writes memory.
- States:
  - IDLE: wait for start. On start: mem_addr<=START_ADDR -> ISSUE.
  - ISSUE: mem_addr is stable on the RAM this cycle -> WAIT.
  - WAIT: RAM output registers. Next cycle -> CAPTURE.
  - CAPTURE: cur_data<=mem_do, cur_addr<=mem_addr, data_valid=1 for this cycle only, dwell counter<=0 -> DWELL.
  - DWELL:
    - If pause=0: the counter increments; at DWELL_CYCLES-1, advance.
    - If pause=1: the counter holds; step advances immediately and resets the counter.
  - Advance:
    - If mem_addr==END_ADDR: with WRAP=1, mem_addr<=START_ADDR -> ISSUE; with WRAP=0 -> DONE.
    - Otherwise mem_addr<=mem_addr+1 -> ISSUE.
  - DONE: done=1, busy=0, cur_* hold. start -> clear done, restart as from IDLE.
- Latency: start to first data_valid = 3 cycles (IDLE->ISSUE->WAIT->CAPTURE). Byte-to-byte period in RUN mode = DWELL_CYCLES+3.
- Address arithmetic is ADDR_W-bit unsigned. END_ADDR=16'hFFFF with WRAP=1 returns to START_ADDR and never relies on natural overflow.
- start while busy is ignored. Scans restart only from IDLE/DONE.
- step while pause=0 is ignored. step and pause falling in the same cycle: step is ignored and the counter resumes.
- pause asserted in ISSUE/WAIT/CAPTURE does not abort the read in flight; it takes effect in DWELL.
- START_ADDR==END_ADDR: single-byte scan. WRAP=1 rereads the same address every period.
- cur_addr/cur_data change only in CAPTURE, so the display never shows a mixed address/data pair.

Test Plan:
- Setup for all scenarios: behavioural sync RAM model with 1-cycle read latency, RAM[16'hFF0F]=8'hED, RAM[16'hFF10]=8'h3C, RAM[16'hFF11]=8'hA5.
- Reset then start, START_ADDR=FF0F, END_ADDR=FF11, DWELL_CYCLES=4, WRAP=0:
  - data_valid pulses 3 cycles after start, showing cur_addr=FF0F, cur_data=ED.
  - Then FF10/3C at +7 cycles and FF11/A5 at +7 more.
  - done=1 and busy=0 afterwards; mem_we=0 throughout.
- Same window with WRAP=1: after FF11/A5, the next data_valid shows FF0F/ED; done never asserts.
- pause=1 held during the dwell of FF0F, then 3 step pulses spaced 10 cycles apart:
  - Each step yields exactly one data_valid: FF10, FF11, then FF0F with WRAP=1.
  - No advance between steps.
- reset_n pulsed low for 2 cycles while in WAIT:
  - All outputs return to reset values asynchronously; no data_valid.
  - A subsequent start restarts at FF0F.
- start pulsed while busy is ignored.
- step with pause=0 is ignored.
- After DONE, start clears done and rescans from FF0F/ED.
